bt_uart_tx: RTL
===============

BT_UART_TX -- requirements
Module: bt_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 2604, giving clock cycles per UART bit (25 MHz clk, 9600 baud, 40 ns period).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving byte buffer entries (power of two, >= 2).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  8  byte to transmit, sampled when wr_en=1.
REQ-006 wr_en  input  1  write strobe; one byte enqueued per cycle high while not full.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH bytes; registered.
REQ-008 overflow  output  1  one-cycle pulse when wr_en=1 while full (byte dropped).
REQ-009 tx  output  1  serial line, 8N1, idle high; drives the Bluetooth module rx input; registered.
REQ-010 busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-011 Frame format SHALL be start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-012 Each bit SHALL be held on tx for exactly CLKS_PER_BIT clock cycles; a frame SHALL last 10*CLKS_PER_BIT cycles.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1; if FIFO non-empty, pop head into shift register, go START, tx<=0 on the same edge.
REQ-015 START -> DATA after CLKS_PER_BIT cycles; DATA shifts one bit per CLKS_PER_BIT cycles using a 3-bit bit index 0..7.
REQ-016 DATA -> STOP after bit index 7 completes; tx<=1 on entering STOP.
REQ-017 At end of STOP: if FIFO non-empty, pop and go directly to START (no idle gap); else go IDLE.
REQ-018 Latency: byte written at edge k into an empty FIFO with FSM in IDLE SHALL make tx fall at edge k+1.
REQ-019 Bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits, reset to 0 at every state/bit transition, never wrap mid-bit.
REQ-020 FIFO pointers SHALL be log2(FIFO_DEPTH) bits with wrap-around; count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-021 full SHALL be derived from the registered count; a write in a cycle where full=1 SHALL be dropped even if a pop occurs in the same cycle, and overflow pulses.
REQ-022 Simultaneous write and pop with FIFO neither full nor empty SHALL leave count unchanged and preserve order.
REQ-023 data_in SHALL be captured at the write edge; later changes SHALL not affect the queued byte.
REQ-024 busy SHALL be 0 only when state=IDLE and FIFO empty.

Reset
REQ-025 On reset=1 at a clock edge: state<=IDLE, tx<=1, counters, bit index and pointers <=0, full<=0, overflow<=0, busy<=0.
REQ-026 Reset mid-frame SHALL abort the frame: tx high from the next edge, all queued bytes discarded.
REQ-027 wr_en asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit), CLK_FREQ=25_000_000, BAUD=9600 and derived CLKS_PER_BIT default.
REQ-029 The FIFO SHALL be a separate sub-module bt_tx_fifo (data, wr_en, rd_en, full, empty, count); FSM and shifter stay in bt_uart_tx.

Verification
REQ-030 Reset then idle 1000 cycles -> tx=1, busy=0, full=0 throughout.
REQ-031 Write 0xA5 (default CLKS_PER_BIT) -> tx falls one cycle later; sampled at mid-bit every 2604 cycles: 0,1,0,1,0,0,1,0,1,1 (104160 ns/bit); busy drops after 26040 cycles.
REQ-032 CLKS_PER_BIT=4: write 0x31,0x32,0x33 on consecutive cycles -> three contiguous 40-cycle frames, no idle gap, bytes in order; loopback into the Bluetooth receiver shows leds=0x33 at end.
REQ-033 CLKS_PER_BIT=4, FIFO_DEPTH=4: six consecutive writes 0x01..0x06 -> first popped to shifter, 0x02..0x05 queued, full=1, 0x06 dropped with one overflow pulse; line carries 0x01..0x05 only.
REQ-034 CLKS_PER_BIT=4: write 0x00, assert reset at cycle 15 of frame -> tx=1 next edge, busy=0, no further frame; subsequent write 0xFF transmits correctly.
REQ-035 Write and pop in the same cycle with count=2 -> count stays 2, output order matches write order.

Source files
------------

// File: rtl/bt_uart_tx_pkg.sv
// Shared constants for the Bluetooth-link UART transmitter: clocking, baud and FSM encoding.
package bt_uart_tx_pkg;

  localparam int CLK_FREQ         = 25_000_000;
  localparam int BAUD             = 9600;
  localparam int CLKS_PER_BIT_DEF = CLK_FREQ / BAUD;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bt_tx_fifo.sv
// Byte FIFO feeding the UART shifter; full is registered so writes never see a same-cycle pop.
module bt_tx_fifo
  import bt_uart_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic [AW:0]   w_count_nxt;
  logic          w_wr;
  logic          w_rd;

  // A write while full is dropped even if the head is popped on the same edge.
  assign w_wr = wr_en & ~r_full & ~reset;
  assign w_rd = rd_en & (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = (r_count == '0);
  assign count   = r_count;

endmodule

// File: rtl/bt_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO, driving the Bluetooth module's rx pin.
module bt_uart_tx
  import bt_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic       full,
  output logic       overflow,
  output logic       tx,
  output logic       busy
);

  localparam int             CW      = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [1:0]                    r_state;
  logic                          r_tx;
  logic [CW-1:0]                 r_cnt;
  logic [2:0]                    r_bit_idx;
  logic [7:0]                    r_shift;
  logic                          r_overflow;
  logic                          w_full;
  logic                          w_empty;
  logic [7:0]                    w_head;
  logic [$clog2(FIFO_DEPTH):0]   w_count;
  logic                          w_bit_end;
  logic                          w_pop;

  assign w_bit_end = (r_cnt == CNT_MAX);
  // Pop from IDLE, or at the last cycle of STOP so back-to-back frames have no gap.
  assign w_pop = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));

  bt_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (data_in),
    .wr_en   (wr_en),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en & w_full;
      case (r_state)
        ST_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= ST_START;
            r_tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= ST_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign full     = w_full;
  assign overflow = r_overflow;
  assign busy     = (r_state != ST_IDLE) | (w_count != '0);

endmodule
